// File: rtl/disp_pkg.sv
// Shared definitions for the display arbiter: requester count, the
// "no owner" code, the hold-counter width, the FSM state encoding and a
// mod-3 increment helper used by the round-robin search.
package disp_pkg;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned CNT_W      = 22;
  localparam logic [1:0]  OWNER_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  // Next requester index, wrapping 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Bus between the three display requesters and the arbiter.
//   req            : per-requester level request (bit i = requester i)
//   val0..val2     : per-requester 16-bit display value
//   pnt0..pnt2     : per-requester 4-bit point-marker pattern
//   gnt            : one-hot registered grant, zero when unowned
//   owner          : binary index of the owner, 2'b11 when unowned
//   dispVal, point : registered value/pattern for the display driver
//   busy           : high while a requester owns the display
// master = requester side, slave = arbiter side.
interface disp_arbiter_if;
  import disp_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [15:0]        val0, val1, val2;
  logic [3:0]         pnt0, pnt1, pnt2;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         owner;
  logic [15:0]        dispVal;
  logic [3:0]         point;
  logic               busy;

  modport master (
    output req, val0, val1, val2, pnt0, pnt1, pnt2,
    input  gnt, owner, dispVal, point, busy
  );

  modport slave (
    input  req, val0, val1, val2, pnt0, pnt1, pnt2,
    output gnt, owner, dispVal, point, busy
  );

endinterface

// File: rtl/disp_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   last   : previous owner; search starts at last+1 (mod 3) and the
//            previous owner itself is checked last
//   winner : first requester found, OWNER_NONE if none
//   valid  : a winner was found
module rr_pick
  import disp_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               valid
);

  logic [3:0] req_x;
  logic [1:0] cand;

  always_comb begin
    req_x  = {1'b0, req};
    winner = OWNER_NONE;
    valid  = 1'b0;
    cand   = last;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = next_idx(cand);
      if (!valid && req_x[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Display arbiter: grants one of three requesters the seven-segment
// display, holding each tenure for at least HOLD cycles before another
// requester may preempt, with a one-cycle blanking gap between owners.
//   clk5  : 5 MHz system clock
//   reset : asynchronous, active-low
//   bus   : disp_arbiter_if slave port (requests in, grant/display out)
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned HOLD     = 2500000,
  parameter logic [15:0] IDLE_VAL = 16'h0000
) (
  input logic           clk5,
  input logic           reset,
  disp_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         last;
  logic [1:0]         owner_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [15:0]        disp_q;
  logic [3:0]         point_q;

  logic [1:0]         win;
  logic               win_valid;
  logic               owner_req;
  logic               others_req;
  logic [15:0]        sel_val;
  logic [3:0]         sel_pnt;

  rr_pick u_pick (
    .req    (bus.req),
    .last   (last),
    .winner (win),
    .valid  (win_valid)
  );

  // gnt_q is the one-hot owner, so it splits req into owner/others.
  always_comb begin
    owner_req  = |(bus.req & gnt_q);
    others_req = |(bus.req & ~gnt_q);
    case (owner_q)
      2'd0:    begin sel_val = bus.val0; sel_pnt = bus.pnt0; end
      2'd1:    begin sel_val = bus.val1; sel_pnt = bus.pnt1; end
      2'd2:    begin sel_val = bus.val2; sel_pnt = bus.pnt2; end
      default: begin sel_val = IDLE_VAL; sel_pnt = '0;       end
    endcase
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= OWNER_NONE;
      disp_q  <= IDLE_VAL;
      point_q <= '0;
      cnt     <= '0;
      last    <= 2'd2;
    end else begin
      case (state)
        // IDLE and SWITCH share the same exit rule; SWITCH only differs
        // in that it is always left after one cycle.
        ST_IDLE, ST_SWITCH: begin
          disp_q  <= IDLE_VAL;
          point_q <= '0;
          if (win_valid) begin
            state   <= ST_GRANT;
            gnt_q   <= NUM_REQ'(1) << win;
            owner_q <= win;
            last    <= win;
            cnt     <= CNT_LOAD;
          end else begin
            state   <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= OWNER_NONE;
          end
        end
        ST_GRANT: begin
          if (!owner_req || (cnt == '0 && others_req)) begin
            state   <= ST_SWITCH;
            gnt_q   <= '0;
            owner_q <= OWNER_NONE;
            disp_q  <= IDLE_VAL;
            point_q <= '0;
          end else begin
            disp_q  <= sel_val;
            point_q <= sel_pnt;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          gnt_q   <= '0;
          owner_q <= OWNER_NONE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.dispVal = disp_q;
  assign bus.point   = point_q;
  assign bus.busy    = (state == ST_GRANT);

endmodule

// File: tb/tb_disp_arbiter.sv
module tb_disp_arbiter;
  import disp_pkg::*;

  localparam int unsigned HOLD_SIM = 8;
  localparam logic [15:0] IDLE_V   = 16'h0000;

  logic clk5  = 1'b0;
  logic reset = 1'b0;
  always #100 clk5 = ~clk5;

  disp_arbiter_if bus ();
  disp_arbiter_if bus1 ();

  disp_arbiter #(.HOLD(HOLD_SIM), .IDLE_VAL(IDLE_V)) dut (
    .clk5 (clk5), .reset (reset), .bus (bus)
  );
  disp_arbiter #(.HOLD(1), .IDLE_VAL(IDLE_V)) dut1 (
    .clk5 (clk5), .reset (reset), .bus (bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the display and for how many cycles.
  int         m_own, m_last, m_ten;
  logic [2:0] e_gnt;
  logic [1:0] e_own;
  logic       e_busy;
  logic [15:0] e_disp;
  logic [3:0] e_pnt;

  task automatic model_reset();
    m_own = -1; m_last = 2; m_ten = 0;
    e_gnt = '0; e_own = 2'b11; e_busy = 1'b0; e_disp = IDLE_V; e_pnt = '0;
  endtask

  task automatic model_step();
    int prev;
    logic [2:0] r;
    logic [15:0] v[3];
    logic [3:0] p[3];
    r = bus.req;
    v[0] = bus.val0; v[1] = bus.val1; v[2] = bus.val2;
    p[0] = bus.pnt0; p[1] = bus.pnt1; p[2] = bus.pnt2;
    prev = m_own;
    if (m_own >= 0) begin
      if (!r[m_own] || (m_ten >= int'(HOLD_SIM) && (r & ~(3'b001 << m_own)) != 3'b000)) begin
        m_last = m_own;
        m_own  = -1;
      end else m_ten++;
    end else if (r != 3'b000) begin
      for (int i = 1; i <= 3; i++) begin
        if (r[(m_last + i) % 3]) begin
          m_own = (m_last + i) % 3;
          break;
        end
      end
      m_ten = 1;
    end
    e_gnt  = (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
    e_own  = (m_own >= 0) ? 2'(m_own) : 2'b11;
    e_busy = (m_own >= 0);
    e_disp = (prev >= 0 && m_own >= 0) ? v[m_own] : IDLE_V;
    e_pnt  = (prev >= 0 && m_own >= 0) ? p[m_own] : 4'b0000;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".gnt"},   32'(bus.gnt),     32'(e_gnt));
    chk({tag, ".owner"}, 32'(bus.owner),   32'(e_own));
    chk({tag, ".busy"},  32'(bus.busy),    32'(e_busy));
    chk({tag, ".disp"},  32'(bus.dispVal), 32'(e_disp));
    chk({tag, ".point"}, 32'(bus.point),   32'(e_pnt));
  endtask

  // Assert reset across two cycles, check reset outputs, release at a negedge.
  task automatic do_reset();
    reset = 1'b0;
    bus.req = '0; bus1.req = '0;
    repeat (2) @(negedge clk5);
    chk("rst.gnt",   32'(bus.gnt),     32'h0);
    chk("rst.owner", 32'(bus.owner),   32'h3);
    chk("rst.busy",  32'(bus.busy),    32'h0);
    chk("rst.disp",  32'(bus.dispVal), 32'(IDLE_V));
    chk("rst.point", 32'(bus.point),   32'h0);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [1:0]  own;
    logic        busy;
    logic [15:0] disp;
    logic [3:0]  pnt;
  } vec_t;

  vec_t tbl[9];
  logic [15:0] vals[3];

  initial begin
    tbl[0] = '{3'b001, 3'b001, 2'd0, 1'b1, 16'h0000, 4'b0000};
    tbl[1] = '{3'b001, 3'b001, 2'd0, 1'b1, 16'h1234, 4'b0100};
    tbl[2] = '{3'b000, 3'b000, 2'd3, 1'b0, 16'h0000, 4'b0000};
    tbl[3] = '{3'b000, 3'b000, 2'd3, 1'b0, 16'h0000, 4'b0000};
    tbl[4] = '{3'b010, 3'b010, 2'd1, 1'b1, 16'h0000, 4'b0000};
    tbl[5] = '{3'b110, 3'b010, 2'd1, 1'b1, 16'hBEEF, 4'b0011};
    tbl[6] = '{3'b100, 3'b000, 2'd3, 1'b0, 16'h0000, 4'b0000};
    tbl[7] = '{3'b101, 3'b100, 2'd2, 1'b1, 16'h0000, 4'b0000};
    tbl[8] = '{3'b101, 3'b100, 2'd2, 1'b1, 16'h5A5A, 4'b1111};

    bus.val0 = 16'h1234; bus.pnt0 = 4'b0100;
    bus.val1 = 16'hBEEF; bus.pnt1 = 4'b0011;
    bus.val2 = 16'h5A5A; bus.pnt2 = 4'b1111;
    bus1.val0 = 16'h1111; bus1.val1 = 16'h2222; bus1.val2 = 16'h3333;
    bus1.pnt0 = '0; bus1.pnt1 = '0; bus1.pnt2 = '0;
    vals[0] = 16'h1234; vals[1] = 16'hBEEF; vals[2] = 16'h5A5A;

    // Directed vector table
    do_reset();
    foreach (tbl[i]) begin
      bus.req = tbl[i].req;
      @(negedge clk5);
      chk($sformatf("tbl%0d.gnt", i),   32'(bus.gnt),     32'(tbl[i].gnt));
      chk($sformatf("tbl%0d.owner", i), 32'(bus.owner),   32'(tbl[i].own));
      chk($sformatf("tbl%0d.busy", i),  32'(bus.busy),    32'(tbl[i].busy));
      chk($sformatf("tbl%0d.disp", i),  32'(bus.dispVal), 32'(tbl[i].disp));
      chk($sformatf("tbl%0d.point", i), 32'(bus.point),   32'(tbl[i].pnt));
    end

    // Full rotation with all three requesting: 8-cycle tenures, blank gaps
    do_reset();
    bus.req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk5);
        chk($sformatf("rot%0d.gnt", r), 32'(bus.gnt), 32'(3'b001 << (r % 3)));
        chk($sformatf("rot%0d.disp", r), 32'(bus.dispVal),
            (c == 0) ? 32'(IDLE_V) : 32'(vals[r % 3]));
      end
      if (r < 3) begin
        @(negedge clk5);
        chk($sformatf("rot%0d.gap.gnt", r),  32'(bus.gnt),     32'h0);
        chk($sformatf("rot%0d.gap.disp", r), 32'(bus.dispVal), 32'(IDLE_V));
        chk($sformatf("rot%0d.gap.busy", r), 32'(bus.busy),    32'h0);
      end
    end

    // Owner drops early: no hold wait
    do_reset();
    bus.req = 3'b011;
    repeat (3) begin
      @(negedge clk5);
      chk("drop.hold.gnt", 32'(bus.gnt), 32'h1);
    end
    bus.req = 3'b010;
    @(negedge clk5);
    chk("drop.gap.gnt", 32'(bus.gnt), 32'h0);
    @(negedge clk5);
    chk("drop.next.gnt", 32'(bus.gnt), 32'h2);

    // Lone owner keeps the display past expiry until someone else asks
    do_reset();
    bus.req = 3'b001;
    repeat (20) begin
      @(negedge clk5);
      chk("lone.gnt", 32'(bus.gnt), 32'h1);
    end
    bus.req = 3'b101;
    @(negedge clk5);
    chk("lone.gap.gnt", 32'(bus.gnt), 32'h0);
    @(negedge clk5);
    chk("lone.next.gnt", 32'(bus.gnt), 32'h4);

    // Asynchronous reset mid-tenure
    do_reset();
    bus.req = 3'b011;
    repeat (3) @(negedge clk5);
    @(posedge clk5);
    #37;
    reset = 1'b0;
    #1;
    chk("arst.gnt",   32'(bus.gnt),     32'h0);
    chk("arst.disp",  32'(bus.dispVal), 32'(IDLE_V));
    chk("arst.owner", 32'(bus.owner),   32'h3);
    chk("arst.busy",  32'(bus.busy),    32'h0);
    bus.req = 3'b110;
    @(negedge clk5);
    reset = 1'b1;
    @(negedge clk5);
    chk("arst.first.gnt",   32'(bus.gnt),   32'h2);
    chk("arst.first.owner", 32'(bus.owner), 32'h1);

    // HOLD=1 instance: preemption on the cycle after grant
    do_reset();
    bus1.req = 3'b011;
    @(negedge clk5); chk("h1.g0.gnt",  32'(bus1.gnt), 32'h1);
    @(negedge clk5); chk("h1.gap.gnt", 32'(bus1.gnt), 32'h0);
    @(negedge clk5); chk("h1.g1.gnt",  32'(bus1.gnt), 32'h2);
    @(negedge clk5); chk("h1.gap2.gnt", 32'(bus1.gnt), 32'h0);
    @(negedge clk5); chk("h1.g2.gnt",  32'(bus1.gnt), 32'h1);
    bus1.req = '0;

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(9) == 0) bus.req[b] = ~bus.req[b];
      bus.val0 = 16'($urandom); bus.val1 = 16'($urandom); bus.val2 = 16'($urandom);
      bus.pnt0 = 4'($urandom);  bus.pnt1 = 4'($urandom);  bus.pnt2 = 4'($urandom);
      @(posedge clk5);
      model_step();
      @(negedge clk5);
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
